tm_mul_arbiter: RTL and testbench
=================================

Name: tm_mul_arbiter

Overview:
- Shares one combinational 32x32 signed tree multiplier (TM) among NREQ requesters.
- Uses round-robin arbitration and registers the operands that drive the multiplier.
- Holds the operands stable for MUL_LAT cycles, so the tree can be treated as a multicycle path.
- Returns the 64-bit product with the requester ID over a valid/ready response channel with backpressure.

Parameters:
- NREQ, 4: number of requesters; legal range 2..16.
- IDW, 2: width of rsp_id; must equal clog2(NREQ).
- MUL_LAT, 2: cycles operands are held before the product is registered; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  NREQ*32  multiplicands; requester i uses bits [32i+31:32i], two's complement.
- req_b  in  NREQ*32  multipliers; same packing as req_a.
- req_ready  out  NREQ  one-hot acceptance strobe.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts the product.
- rsp_data  out  64  signed product a*b.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, rr_ptr=0, op_a=0, op_b=0, lat_cnt=0, rsp_valid=0, rsp_data=0, rsp_id=0. An in-flight operation is discarded and produces no response.
- Multiplier: a single TM instance, inputs op_a/op_b, product wire prod[63:0]. Full 64-bit signed result with no truncation; -2^31 * -2^31 = 0x4000_0000_0000_0000.
- FSM states are IDLE, MUL, HOLD.
- IDLE, arbitration:
  - Grant g is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1 combinationally, only in IDLE and only when at least one req_valid is set; all other req_ready bits are 0.
  - On that edge: op_a<=req_a[g], op_b<=req_b[g], gnt_id<=g, rr_ptr<=(g+1) mod NREQ, lat_cnt<=0, state<=MUL.
  - With no request, remain in IDLE; rr_ptr is unchanged.
- MUL: lat_cnt increments each edge. op_a and op_b must not change in this state.
  - When lat_cnt==MUL_LAT-1: rsp_data<=prod, rsp_id<=gnt_id, rsp_valid<=1, state<=HOLD.
  - Latency: rsp_valid goes high MUL_LAT edges after the accepting edge.
- HOLD: rsp_valid, rsp_data and rsp_id stay stable until the rsp_valid&&rsp_ready edge. On that edge rsp_valid<=0 and state<=IDLE.
- Handshakes and throughput:
  - req_ready is always 0 in MUL and HOLD, so a requester must hold req_valid and its operands until it is accepted.
  - No new grant is issued in the same cycle as the response handshake.
  - Maximum throughput is one operation per MUL_LAT+2 cycles.
- Boundary conditions:
  - If req_valid drops while not granted, the request is ignored with no side effects.
  - If rsp_ready is high when HOLD is entered, the handshake completes on the first HOLD edge.
  - rr_ptr wraps from NREQ-1 to 0.
  - With a single active requester, that requester is granted back-to-back.
- busy = (state!=IDLE).

Optional Feature:
- Macro: TM_MUL_ARBITER_PERF_EN.
- When defined, two extra output ports are added:
  - ops_count out 32: increments on each rsp_valid&&rsp_ready edge.
  - stall_count out 32: increments on each edge spent in HOLD with rsp_ready=0.
  - Both counters reset to 0 and wrap from 0xFFFF_FFFF to 0.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Basic signed multiply, MUL_LAT=2: req_valid=0001, a0=0xFFFF_FFFD (-3), b0=7, rsp_ready=1. Expect req_ready=0001 for 1 cycle, rsp_valid 2 edges later with rsp_data=0xFFFF_FFFF_FFFF_FFEB, rsp_id=0; busy high from acceptance through the handshake.
- Corner operands: a=b=0x8000_0000 gives 0x4000_0000_0000_0000. a=0x7FFF_FFFF, b=0x8000_0000 gives 0xC000_0000_8000_0000. a=0, b=0x1234 gives 0.
- Round-robin fairness: req_valid=1111 held with distinct operands on each requester, rsp_ready=1. Grant order must be 0,1,2,3,0, each rsp_id matching its own product, and grants spaced MUL_LAT+2 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles in HOLD. rsp_valid, rsp_data and rsp_id stay stable and req_ready stays 0000; when rsp_ready rises, the handshake completes in 1 cycle. With TM_MUL_ARBITER_PERF_EN defined, stall_count=5 and ops_count=1.
- Reset mid-operation: assert rst_n=0 while in MUL. All outputs go to 0 immediately (asynchronous). After release, rsp_valid stays 0 and the next grant starts from requester 0.
- Sparse requests: req_valid=0100, then 0010 after the response. Grants go to 2 and then 1, rr_ptr becomes 2 after the second grant, and no spurious req_ready appears while idle.

Source files
------------

// File: rtl/tm_mul_arbiter.sv
// tm_mul_arbiter: round-robin arbiter sharing one 32x32 signed tree multiplier.
// Operands are registered and held for MUL_LAT cycles so the multiplier can be
// constrained as a multicycle path. The product and requester ID are returned
// over a valid/ready channel.
// Optional build macro: TM_MUL_ARBITER_PERF_EN adds ops_count / stall_count.
//
// state | meaning
// IDLE  | arbitrating; req_ready may assert for the granted requester
// MUL   | operands held, waiting MUL_LAT edges for the tree to settle
// HOLD  | product presented on rsp_*, waiting for rsp_ready

module tm_tree_mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    // Sign-extend both operands to 64 bits; the low 64 bits of the unsigned
    // product are then the exact signed product.
    assign p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
endmodule

module tm_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
`ifdef TM_MUL_ARBITER_PERF_EN
    output logic [31:0]          ops_count,
    output logic [31:0]          stall_count,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_nxt;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] gnt_sel;
    logic           gnt_any;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic [31:0]    op_a;
    logic [31:0]    op_b;
    logic [3:0]     lat_cnt;
    logic [63:0]    prod;
    logic           accept;
    logic           lat_done;
    logic           rsp_fire;
    int             arb_idx;

    tm_tree_mul u_tm (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // Round-robin search starting at rr_ptr; also muxes the winner's operands.
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = '0;
        sel_a   = '0;
        sel_b   = '0;
        arb_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_any && req_valid[arb_idx]) begin
                gnt_any = 1'b1;
                gnt_sel = IDW'(arb_idx);
                sel_a   = req_a[arb_idx*32 +: 32];
                sel_b   = req_b[arb_idx*32 +: 32];
            end
        end
    end

    assign rr_nxt   = (gnt_sel == IDW'(NREQ - 1)) ? '0 : gnt_sel + 1'b1;
    assign accept   = (state == IDLE) && gnt_any;
    assign lat_done = (state == MUL) && (lat_cnt == 4'(MUL_LAT - 1));
    assign rsp_fire = (state == HOLD) && rsp_valid && rsp_ready;
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the one-hot acceptance strobe.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    req_ready = NREQ'(1) << gnt_sel;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (lat_done) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (rsp_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, pointer advance and latency counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            gnt_id  <= '0;
            rr_ptr  <= '0;
            lat_cnt <= '0;
        end else if (accept) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            gnt_id  <= gnt_sel;
            rr_ptr  <= rr_nxt;
            lat_cnt <= '0;
        end else if (state == MUL) begin
            lat_cnt <= lat_cnt + 1'b1;
        end
    end

    // Response register; data and id stay put after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (lat_done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= prod;
            rsp_id    <= gnt_id;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef TM_MUL_ARBITER_PERF_EN
    // Completed operations and cycles lost to response backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_count   <= '0;
            stall_count <= '0;
        end else begin
            if (rsp_fire) begin
                ops_count <= ops_count + 32'd1;
            end
            if ((state == HOLD) && !rsp_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tm_mul_arbiter.sv
// Bench for tm_mul_arbiter: transaction-level reference model checked on every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_tm_mul_arbiter;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int MUL_LAT = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*32-1:0]  req_a = '0;
    logic [NREQ*32-1:0]  req_b = '0;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [63:0]         rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic                busy;
`ifdef TM_MUL_ARBITER_PERF_EN
    logic [31:0]         ops_count;
    logic [31:0]         stall_count;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    tm_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
`ifdef TM_MUL_ARBITER_PERF_EN
        .ops_count  (ops_count),
        .stall_count(stall_count),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase = edges since acceptance, -1 when idle.
    int          m_phase = -1;
    int          m_ptr = 0;
    logic        m_valid = 1'b0;
    logic [63:0] m_data = '0;
    logic [IDW-1:0] m_id = '0;
    logic [63:0] m_pend_data = '0;
    int          m_pend_id = 0;
    int          gq[$];
    int          cq[$];

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        pa = longint'($signed(a)) * longint'($signed(b));
        return 64'(pa);
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        if (!rst_n) begin
            m_phase = -1; m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = '0;
        end
        exp_rdy = '0;
        g = -1;
        if (rst_n && m_phase < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("busy", 64'(busy), 64'(m_phase >= 0));
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("rsp_data", rsp_data, m_data);
        check("rsp_id", 64'(rsp_id), 64'(m_id));
        if (rst_n) begin
            if (m_phase < 0) begin
                if (g >= 0) begin
                    gq.push_back(g);
                    cq.push_back(cyc);
                    m_pend_data = ref_prod(req_a[32*g +: 32], req_b[32*g +: 32]);
                    m_pend_id = g;
                    m_ptr = (g + 1) % NREQ;
                    m_phase = 0;
                end
            end else if (m_valid) begin
                if (rsp_ready) begin
                    m_valid = 1'b0;
                    m_phase = -1;
                end
            end else begin
                m_phase++;
                if (m_phase == MUL_LAT) begin
                    m_valid = 1'b1;
                    m_data = m_pend_data;
                    m_id = IDW'(m_pend_id);
                end
            end
        end
    end

    // Returns at posedge+1 just after the accepting edge.
    task automatic wait_accept(output int g);
        g = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req_ready != '0) begin
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("accept_timeout", 64'(1), 64'(0));
    endtask

    // Returns at posedge+1 of the edge that raised rsp_valid.
    task automatic wait_rsp();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) return;
        end
        check("rsp_timeout", 64'(1), 64'(0));
    endtask

    task automatic pulse_reset();
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    task automatic run_single(input int id, input logic [31:0] a, input logic [31:0] b,
                              input logic [63:0] exp);
        int g;
        set_op(id, a, b);
        rsp_ready = 1'b1;
        req_valid = NREQ'(1) << id;
        wait_accept(g);
        req_valid = '0;
        check("single_gnt", 64'(g), 64'(id));
        wait_rsp();
        check("single_data", rsp_data, exp);
        check("single_id", 64'(rsp_id), 64'(id));
        @(posedge clk); #1;
        check("single_done", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        logic [63:0] hd;
        logic [IDW-1:0] hid;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic signed multiply with exact latency
        set_op(0, 32'hFFFF_FFFD, 32'd7);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1 check("basic_ready", 64'(req_ready), 64'(4'b0001));
        wait_accept(g);
        check("basic_gnt", 64'(g), 64'(0));
        check("basic_ready_after", 64'(req_ready), 64'(0));
        check("basic_busy", 64'(busy), 64'(1));
        req_valid = '0;
        @(posedge clk); #1;
        check("basic_lat1", 64'(rsp_valid), 64'(0));
        @(posedge clk); #1;
        check("basic_lat2", 64'(rsp_valid), 64'(1));
        check("basic_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFEB);
        check("basic_id", 64'(rsp_id), 64'(0));
        check("basic_busy_hold", 64'(busy), 64'(1));
        @(posedge clk); #1;
        check("basic_done", 64'(rsp_valid), 64'(0));
        check("basic_idle", 64'(busy), 64'(0));

        // Corner operands
        run_single(1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_single(3, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        run_single(2, 32'h0000_0000, 32'h0000_1234, 64'h0);

        // Round-robin fairness from a fresh pointer
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 2), 32'(-(i + 1) * 1000));
        gq.delete(); cq.delete();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 60 && gq.size() < 5; i++) begin
            @(posedge clk); #1;
        end
        req_valid = '0;
        check("rr_count", 64'(gq.size()), 64'(5));
        if (gq.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("rr_order", 64'(gq[i]), 64'(i % NREQ));
            for (int i = 1; i < 5; i++) check("rr_spacing", 64'(cq[i] - cq[i-1]), 64'(MUL_LAT + 2));
        end
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk); #1;
        end

        // Backpressure
        pulse_reset();
        set_op(1, 32'd5, 32'hFFFF_FFFE);
        set_op(2, 32'd9, 32'd9);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        wait_accept(g);
        req_valid = '0;
        wait_rsp();
        check("bp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFF6);
        check("bp_id", 64'(rsp_id), 64'(1));
        hd = rsp_data;
        hid = rsp_id;
        req_valid = 4'b0100;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid_hold", 64'(rsp_valid), 64'(1));
            check("bp_data_hold", rsp_data, hd);
            check("bp_id_hold", 64'(rsp_id), 64'(hid));
            check("bp_no_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake", 64'(rsp_valid), 64'(0));
`ifdef TM_MUL_ARBITER_PERF_EN
        check("bp_stall_count", 64'(stall_count), 64'(5));
        check("bp_ops_count", 64'(ops_count), 64'(1));
`endif
        wait_accept(g);
        req_valid = '0;
        check("bp_next_gnt", 64'(g), 64'(2));
        wait_rsp();
        check("bp_next_data", rsp_data, 64'd81);
        @(posedge clk); #1;

        // Reset in the middle of an operation
        set_op(0, 32'd3, 32'd4);
        req_valid = 4'b0001;
        wait_accept(g);
        req_valid = '0;
        check("mid_busy", 64'(busy), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rsp_data", rsp_data, 64'h0);
        check("mid_rsp_id", 64'(rsp_id), 64'(0));
        check("mid_busy_rst", 64'(busy), 64'(0));
        check("mid_req_ready", 64'(req_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("mid_no_rsp", 64'(rsp_valid), 64'(0));
        end
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'd10);
        req_valid = 4'b1111;
        wait_accept(g);
        req_valid = '0;
        check("mid_first_gnt", 64'(g), 64'(0));
        wait_rsp();
        check("mid_data", rsp_data, 64'd10);
        @(posedge clk); #1;

        // Sparse requests
        run_single(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        run_single(1, 32'd100000, 32'd100000, 64'd10000000000);
        repeat (3) begin
            @(posedge clk); #1;
            check("sparse_idle_ready", 64'(req_ready), 64'(0));
        end
        set_op(0, 32'd6, 32'd7);
        set_op(2, 32'd8, 32'd9);
        req_valid = 4'b0101;
        wait_accept(g);
        req_valid = '0;
        check("sparse_ptr_gnt", 64'(g), 64'(2));
        wait_rsp();
        check("sparse_ptr_data", rsp_data, 64'd72);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
